// File: rtl/contador_param.sv
// contador_param: WIDTH-bit up/down timer with auto-reload or one-shot,
// compare match pulse and sticky terminal interrupt.
module contador_param #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iClkE,
    input  logic [WIDTH-1:0] ivReload,
    input  logic [WIDTH-1:0] ivCompare,
    input  logic             iUpDown,
    input  logic             iOneShot,
    input  logic             iStart,
    input  logic             iStop,
    input  logic             iSenalCont,
    input  logic             iFlagClr,
    output logic [WIDTH-1:0] ovCuenta,
    output logic             oRunning,
    output logic             oTerminal,
    output logic             oCompareFlag,
    output logic             oIrq
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] cuenta;
    logic [WIDTH-1:0] cuentaNext;
    logic [WIDTH-1:0] loadVal;
    logic [WIDTH-1:0] termVal;
    logic             terminal;
    logic             terminalNext;
    logic             compare;
    logic             compareNext;
    logic             irq;
    logic             irqNext;
    logic             updated;

    assign loadVal = iUpDown ? '0 : ivReload;
    assign termVal = iUpDown ? ivReload : '0;

    always_comb begin
        stateNext    = state;
        cuentaNext   = cuenta;
        terminalNext = 1'b0;
        compareNext  = 1'b0;
        irqNext      = irq;
        updated      = 1'b0;
        if (iClkE) begin
            if (iFlagClr)
                irqNext = 1'b0;
            unique case (state)
                IDLE: begin
                    if (iStart) begin
                        stateNext  = RUN;
                        cuentaNext = loadVal;
                    end
                end
                RUN: begin
                    if (iStop) begin
                        stateNext = IDLE;
                    end else if (iStart) begin
                        cuentaNext = loadVal;
                        updated    = 1'b1;
                    end else if (cuenta == termVal) begin
                        // Terminal fires on the tick even without an event.
                        terminalNext = 1'b1;
                        irqNext      = 1'b1;
                        if (iOneShot) begin
                            stateNext = DONE;
                        end else begin
                            cuentaNext = loadVal;
                            updated    = 1'b1;
                        end
                    end else if (iSenalCont) begin
                        cuentaNext = iUpDown ? cuenta + 1'b1 : cuenta - 1'b1;
                        updated    = 1'b1;
                    end
                end
                DONE: begin
                    if (iStop) begin
                        stateNext = IDLE;
                    end else if (iStart) begin
                        stateNext  = RUN;
                        cuentaNext = loadVal;
                    end
                end
                default: stateNext = IDLE;
            endcase
            compareNext = updated && (cuentaNext == ivCompare);
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state    <= IDLE;
            cuenta   <= loadVal;
            terminal <= 1'b0;
            compare  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            state    <= stateNext;
            cuenta   <= cuentaNext;
            terminal <= terminalNext;
            compare  <= compareNext;
            irq      <= irqNext;
        end
    end

    assign ovCuenta     = cuenta;
    assign oRunning     = (state == RUN);
    assign oTerminal    = terminal;
    assign oCompareFlag = compare;
    assign oIrq         = irq;

endmodule

// File: tb/tb_contador_param.sv
// Directed self-checking bench for contador_param (WIDTH=8).
module tb_contador_param;

    logic       iClk = 1'b0;
    logic       iReset;
    logic       iClkE;
    logic [7:0] ivReload;
    logic [7:0] ivCompare;
    logic       iUpDown;
    logic       iOneShot;
    logic       iStart;
    logic       iStop;
    logic       iSenalCont;
    logic       iFlagClr;
    logic [7:0] ovCuenta;
    logic       oRunning;
    logic       oTerminal;
    logic       oCompareFlag;
    logic       oIrq;

    int nChecks = 0;
    int nPass   = 0;

    always #5 iClk = ~iClk;

    contador_param #(.WIDTH(8)) dut (
        .iClk        (iClk),
        .iReset      (iReset),
        .iClkE       (iClkE),
        .ivReload    (ivReload),
        .ivCompare   (ivCompare),
        .iUpDown     (iUpDown),
        .iOneShot    (iOneShot),
        .iStart      (iStart),
        .iStop       (iStop),
        .iSenalCont  (iSenalCont),
        .iFlagClr    (iFlagClr),
        .ovCuenta    (ovCuenta),
        .oRunning    (oRunning),
        .oTerminal   (oTerminal),
        .oCompareFlag(oCompareFlag),
        .oIrq        (oIrq)
    );

    task automatic chkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
        nChecks++;
        if (obs === exp)
            nPass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        int expC;
        int cnt;
        logic expT;

        iReset     = 1'b1;
        iClkE      = 1'b1;
        ivReload   = 8'd5;
        ivCompare  = 8'd2;
        iUpDown    = 1'b0;
        iOneShot   = 1'b0;
        iStart     = 1'b0;
        iStop      = 1'b0;
        iSenalCont = 1'b1;
        iFlagClr   = 1'b0;
        step();
        step();
        chkVal("rst_cnt", ovCuenta, 5);
        chkVal("rst_run", oRunning, 0);
        chkVal("rst_term", oTerminal, 0);
        chkVal("rst_cmp", oCompareFlag, 0);
        chkVal("rst_irq", oIrq, 0);

        // Down, continuous, R=5, C=2
        iReset = 1'b0;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        chkVal("start_cnt", ovCuenta, 5);
        chkVal("start_run", oRunning, 1);
        for (int i = 0; i < 12; i++) begin
            step();
            expC = (i % 6 == 5) ? 5 : 4 - (i % 6);
            chkVal("dn_cnt", ovCuenta, expC);
            chkVal("dn_term", oTerminal, (i % 6 == 5) ? 1 : 0);
            chkVal("dn_cmp", oCompareFlag, (expC == 2) ? 1 : 0);
            chkVal("dn_irq", oIrq, (i >= 5) ? 1 : 0);
        end

        // Flag clear coincident with terminal: set wins
        for (int i = 0; i < 5; i++) step();
        chkVal("pre_clr_cnt", ovCuenta, 0);
        iFlagClr = 1'b1;
        step();
        chkVal("clr_coinc_term", oTerminal, 1);
        chkVal("clr_coinc_irq", oIrq, 1);
        chkVal("clr_coinc_cnt", ovCuenta, 5);
        step();
        iFlagClr = 1'b0;
        chkVal("clr_irq", oIrq, 0);
        chkVal("clr_cnt", ovCuenta, 4);

        // Stop at 4 freezes count
        iStop = 1'b1;
        step();
        iStop = 1'b0;
        chkVal("stop4_cnt", ovCuenta, 4);
        chkVal("stop4_run", oRunning, 0);
        step();
        chkVal("stop4_hold", ovCuenta, 4);

        // Restart, stop at 2: no compare pulse while stopped
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        chkVal("rst5_cnt", ovCuenta, 5);
        step();
        step();
        step();
        chkVal("at2_cnt", ovCuenta, 2);
        chkVal("at2_cmp", oCompareFlag, 1);
        iStop = 1'b1;
        step();
        iStop = 1'b0;
        chkVal("stop2_cnt", ovCuenta, 2);
        chkVal("stop2_cmp", oCompareFlag, 0);
        chkVal("stop2_run", oRunning, 0);
        step();
        chkVal("stop2_hold_cmp", oCompareFlag, 0);

        // R=9, reset mid-count at 3
        ivReload = 8'd9;
        iStart   = 1'b1;
        step();
        iStart = 1'b0;
        chkVal("r9_cnt", ovCuenta, 9);
        for (int i = 0; i < 6; i++) step();
        chkVal("r9_at3", ovCuenta, 3);
        iReset = 1'b1;
        step();
        chkVal("midrst_cnt", ovCuenta, 9);
        chkVal("midrst_run", oRunning, 0);
        chkVal("midrst_term", oTerminal, 0);
        chkVal("midrst_cmp", oCompareFlag, 0);
        chkVal("midrst_irq", oIrq, 0);

        // Up, one-shot, R=3
        iReset   = 1'b0;
        iUpDown  = 1'b1;
        iOneShot = 1'b1;
        ivReload = 8'd3;
        iStart   = 1'b1;
        step();
        iStart = 1'b0;
        chkVal("up_start", ovCuenta, 0);
        chkVal("up_run", oRunning, 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chkVal("up_cnt", ovCuenta, i);
            chkVal("up_cmp", oCompareFlag, (i == 2) ? 1 : 0);
            chkVal("up_term_early", oTerminal, 0);
        end
        step();
        chkVal("os_cnt", ovCuenta, 3);
        chkVal("os_term", oTerminal, 1);
        chkVal("os_run", oRunning, 0);
        chkVal("os_irq", oIrq, 1);
        step();
        chkVal("done_cnt", ovCuenta, 3);
        chkVal("done_term", oTerminal, 0);
        chkVal("done_run", oRunning, 0);
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        chkVal("os_restart_cnt", ovCuenta, 0);
        chkVal("os_restart_run", oRunning, 1);

        // Sparse ticks, up continuous R=1, alternating events on ticks
        iOneShot = 1'b0;
        ivReload = 8'd1;
        cnt = 0;
        for (int k = 0; k < 32; k++) begin
            iClkE      = (k % 4 == 0);
            iSenalCont = ((k / 4) % 2 == 0);
            expT = 1'b0;
            if (iClkE) begin
                if (cnt == 1) begin
                    cnt  = 0;
                    expT = 1'b1;
                end else if (iSenalCont) begin
                    cnt = cnt + 1;
                end
            end
            step();
            chkVal("ce_cnt", ovCuenta, cnt);
            chkVal("ce_term", oTerminal, expT);
            chkVal("ce_cmp", oCompareFlag, 0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/contador_param.md
# contador_param

Parametrised timer/counter: WIDTH-bit, up or down, continuous auto-reload or one-shot, with run/stop control, a programmable compare match and a sticky interrupt flag. It counts qualified events (iSenalCont) on clock-enable ticks (iClkE) and signals terminal count and compare match to the surrounding microprocessor-style peripheral logic.

## Interface
- WIDTH, 8, counter, reload and compare width.
- iClk  in  1  system clock; all state updates on the rising edge.
- iReset  in  1  synchronous, active-high reset; overrides everything, ignores iClkE.
- iClkE  in  1  tick enable; all non-reset state updates happen only on edges where iClkE=1.
- ivReload  in  WIDTH  reload value R.
- ivCompare  in  WIDTH  compare value C.
- iUpDown  in  1  0 = count down R→0; 1 = count up 0→R.
- iOneShot  in  1  0 = continuous auto-reload; 1 = stop in DONE at terminal.
- iStart  in  1  start/restart request (tick-qualified).
- iStop  in  1  stop request (tick-qualified).
- iSenalCont  in  1  count event (tick-qualified).
- iFlagClr  in  1  clears oIrq (tick-qualified).
- ovCuenta  out  WIDTH  current count (registered).
- oRunning  out  1  high while state = RUN.
- oTerminal  out  1  one-iClk pulse on terminal event.
- oCompareFlag  out  1  one-iClk pulse on compare match.
- oIrq  out  1  sticky terminal flag.

## Operation
- Load value L = iUpDown ? 0 : R; terminal value T = iUpDown ? R : 0. Both evaluated combinationally from current inputs.
- States: IDLE, RUN, DONE. Reset: IDLE, ovCuenta = L, oRunning/oTerminal/oCompareFlag/oIrq = 0.
- IDLE (tick): iStart → RUN, count = L; otherwise count held.
- RUN (tick), priority order:
  - iStop → IDLE, count frozen.
  - iStart → stay RUN, count = L (restart).
  - count == T → terminal event: oTerminal pulse, oIrq set; continuous: count = L, stay RUN; one-shot: → DONE, count held at T. Terminal event does not need iSenalCont.
  - iSenalCont → count ± 1, modulo 2^WIDTH (up wraps all-ones→0, down cannot pass 0 since 0 is T in down mode).
  - else hold.
- DONE (tick): iStop → IDLE; iStart → RUN, count = L; else hold.
- Compare: oCompareFlag pulses when, in RUN, a tick changes the count (increment, decrement, reload or restart) and the new value equals C. No pulse in IDLE/DONE or when count is merely held.
- oIrq: set on terminal event; cleared by iFlagClr on a tick; set wins when both coincide.
- R = 0: L = T; in RUN every tick is a terminal event (continuous: pulse every tick; one-shot: DONE on first tick).
- iUpDown/ivReload changed while running: take effect immediately on L/T; up mode with count > R counts up through wrap until count == T.
- iReset at any point (mid-count, in DONE, coincident with any tick): next-edge state equals reset state.

## Timing
- All outputs registered; one iClk latency from the qualifying tick edge.
- oTerminal, oCompareFlag: high for exactly one iClk cycle after the updating edge, cleared on the next edge regardless of iClkE.
- Continuous mode, iClkE = iSenalCont = 1: terminal period R+1 cycles in both directions.
- Inputs sampled only on tick edges; callers hold iStart/iStop/iFlagClr until a tick occurs.
- oRunning asserts on the edge that enters RUN, deasserts on the edge that leaves it.

## Test plan
- WIDTH=8, R=5, down, continuous, iClkE=iSenalCont=1, iStart one tick → ovCuenta 5,4,3,2,1,0,5,…; oTerminal pulse every 6 cycles on edge after 0; oIrq=1 from first terminal.
- Up, one-shot, R=3 → 0,1,2,3 then DONE holding 3, single oTerminal, oRunning=0; iStart → restarts at 0, RUN.
- iClkE high 1 cycle in 4, iSenalCont alternating → count changes only on edges with both high; pulses still one iClk wide.
- Down, R=5, C=2 → one oCompareFlag pulse when count becomes 2 per period; none while stopped at 2 via iStop.
- oIrq=1, iFlagClr coincident with terminal → oIrq stays 1; iFlagClr alone next tick → oIrq=0.
- Down, R=9, iReset while ovCuenta=3 → next edge ovCuenta=9, IDLE, all flags 0; separately iStop at 4 → count frozen at 4, oRunning=0.
